// File: rtl/direction_encoder_pkg.sv
// Shared direction encoding for the direction encoder and the snake game logic.
// Directions are one-hot so the game logic can decode them with single-bit tests.
package direction_encoder_pkg;

    typedef logic [4:0] dir_t;

    localparam dir_t DIR_NONE  = 5'b00000;
    localparam dir_t DIR_UP    = 5'b10000;
    localparam dir_t DIR_DOWN  = 5'b01000;
    localparam dir_t DIR_LEFT  = 5'b00100;
    localparam dir_t DIR_RIGHT = 5'b00010;
    localparam dir_t DIR_PAUSE = 5'b00001;

    // 180-degree reversal of a direction; none has no opposite.
    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_NONE;
        endcase
        return r;
    endfunction

    // Pick the single highest-priority press: up > down > left > right.
    function automatic dir_t dir_select(input logic up, input logic down,
                                        input logic left, input logic right);
        dir_t r;
        if (up) begin
            r = DIR_UP;
        end else if (down) begin
            r = DIR_DOWN;
        end else if (left) begin
            r = DIR_LEFT;
        end else if (right) begin
            r = DIR_RIGHT;
        end else begin
            r = DIR_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/direction_encoder_button_debouncer.sv
// One push-button channel: 2-flop synchronizer, debounce counter and
// rising-edge detector producing a single-cycle press pulse.
// A button held through reset never produces a press: presses are only
// armed once a genuine low sample has been synchronized after reset.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_r;
    logic [1:0]       fill_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             prev_r;
    logic             armed_r;
    logic             press_r;

    // Synchronize the raw button and track when the synchronizer holds real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
            fill_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
            fill_r <= {fill_r[0], 1'b1};
        end
    end

    // Debounce: flip the level once DEBOUNCE_CYCLES differing samples in a row were counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= ~level_r;
        end else if (sync_r[1] != level_r) begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r   <= {CNT_W{1'b0}};
        end
    end

    // Edge detect the debounced level into a one-cycle press, gated until armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            prev_r  <= level_r;
            press_r <= level_r & ~prev_r & armed_r;
            if (fill_r[1] && !sync_r[1] && !level_r) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/direction_encoder.sv
// Turns five bouncing push-buttons into a registered one-hot snake direction.
// Holds a pending direction (latest accepted press) and a committed direction
// (what the snake last moved in); reversal presses against the effective
// commit are rejected, and the center button toggles pause.
module direction_encoder
    import direction_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic       in_btn_up,
    input  logic       in_btn_down,
    input  logic       in_btn_left,
    input  logic       in_btn_right,
    input  logic       in_btn_center,
    input  logic       in_step_tick,
    output logic [4:0] out_direction
);

    logic [4:0] btn_raw_s;
    logic [4:0] press_s;
    dir_t       sel_s;
    dir_t       eff_commit_s;
    dir_t       pend_next_s;
    dir_t       commit_next_s;
    logic       paused_next_s;
    dir_t       out_next_s;
    dir_t       pend_r;
    dir_t       commit_r;
    logic       paused_r;

    assign btn_raw_s = {in_btn_up, in_btn_down, in_btn_left, in_btn_right, in_btn_center};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk   (in_clock),
            .rst_n (in_reset_n),
            .btn   (btn_raw_s[i]),
            .press (press_s[i])
        );
    end

    // Arbitrate presses, reject reversals, apply pause and compute the next output.
    always_comb begin
        sel_s         = dir_select(press_s[4], press_s[3], press_s[2], press_s[1]);
        eff_commit_s  = DIR_NONE;
        pend_next_s   = pend_r;
        commit_next_s = commit_r;
        paused_next_s = paused_r ^ press_s[0];
        out_next_s    = DIR_NONE;

        // A tick in this cycle means the snake is about to move in pend.
        if (in_step_tick) begin
            eff_commit_s = pend_r;
        end else begin
            eff_commit_s = commit_r;
        end

        // Direction presses see the pre-toggle pause state.
        if (!paused_r && (sel_s != DIR_NONE) &&
            ((eff_commit_s == DIR_NONE) || (sel_s != dir_opposite(eff_commit_s)))) begin
            pend_next_s = sel_s;
        end else begin
            pend_next_s = pend_r;
        end

        if (in_step_tick && !paused_r) begin
            commit_next_s = pend_r;
        end else begin
            commit_next_s = commit_r;
        end

        if (paused_next_s) begin
            out_next_s = DIR_PAUSE;
        end else begin
            out_next_s = pend_next_s;
        end
    end

    // Direction state and registered output.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            pend_r        <= DIR_NONE;
            commit_r      <= DIR_NONE;
            paused_r      <= 1'b0;
            out_direction <= DIR_NONE;
        end else begin
            pend_r        <= pend_next_s;
            commit_r      <= commit_next_s;
            paused_r      <= paused_next_s;
            out_direction <= out_next_s;
        end
    end

endmodule

// File: doc/direction_encoder.md
DIRECTION_ENCODER -- requirements
Module: direction_encoder

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 500000 (5 ms at 100 MHz), the count of consecutive stable synchronized samples needed to accept a button level.
REQ-002 in_clock  input  1  system clock; all state SHALL be on its rising edge.
REQ-003 in_reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_btn_up, in_btn_down, in_btn_left, in_btn_right, in_btn_center  input  1 each  raw, unsynchronized, bouncing push-buttons, active-high.
REQ-005 in_step_tick  input  1  single-cycle pulse in the in_clock domain, asserted once per snake move, when the game logic consumes the direction.
REQ-006 out_direction  output  5  one-hot direction to the game logic, registered: 10000 up, 01000 down, 00100 left, 00010 right, 00001 paused, 00000 none.

Function
REQ-007 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-008 Each debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it; any sample matching the current level SHALL clear the counter.
REQ-009 A press SHALL be a debounced 0->1 transition, registered as a one-cycle pulse; a held button SHALL produce one press only.
REQ-010 out_direction SHALL change exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples a new stable raw level.
REQ-011 The block SHALL hold a pending direction (pend) and a committed direction (commit); both SHALL be in {none, up, down, left, right}.
REQ-012 On in_step_tick, commit SHALL load pend.
REQ-013 A direction press SHALL load pend unless it is the 180-degree opposite of the effective commit; the effective commit SHALL be pend when in_step_tick is high in the same cycle, and commit otherwise.
REQ-014 When commit is none, every direction press SHALL be accepted.
REQ-015 If several direction presses occur in one cycle, only the highest-priority press SHALL be evaluated, in the order up > down > left > right.
REQ-016 A center press SHALL toggle a paused flag.
REQ-017 While paused, out_direction SHALL be 00001, direction presses SHALL be ignored, and in_step_tick SHALL NOT update commit.
REQ-018 When unpaused, out_direction SHALL be the one-hot encoding of pend.
REQ-019 A center press and a direction press in the same cycle SHALL apply the pause toggle and evaluate the direction press against the pre-toggle paused state.

Reset
REQ-020 Asserting in_reset_n low SHALL immediately clear, at any time including mid-debounce, all of the following: synchronizers, debounced levels, counters, press pulses, pend, commit, paused flag, and out_direction (00000).
REQ-021 After reset, no press SHALL be generated for a button that is already held; a press SHALL require a debounced low-to-high transition.

Structure
REQ-022 A shared package SHALL hold the one-hot constants DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT and DIR_PAUSE, for reuse by snake_logic.
REQ-023 The synchronizer, debounce counter (width clog2(DEBOUNCE_CYCLES+1)) and edge detector SHALL be one sub-module, button_debouncer, instantiated five times.
REQ-024 Direction arbitration, reversal check and pause logic SHALL be in direction_encoder itself.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Reset check: in_reset_n low for 3 cycles, then release with all buttons low -> out_direction=00000 for 20 cycles.
REQ-026 Debounce check: pulse right high for 3 cycles, then low -> out_direction stays 00000; hold right high -> out_direction=00010 exactly 8 edges after the first sampling edge.
REQ-027 Reversal check: with right committed by a tick, press left -> out_direction stays 00010; then press up -> 10000.
REQ-028 Double-tap check: with right committed, press up, then press left before the next tick -> out_direction=10000; after a tick, press left -> 00100.
REQ-029 Simultaneous-press check: up and right rise in the same cycle from none -> out_direction=10000.
REQ-030 Pause check: press center -> 00001; press down while paused -> no change; press center again -> previous direction restored; in_reset_n low mid-debounce -> 00000 immediately.
